// File: rtl/soc_periph_demux.sv
// rtl/soc_periph_demux.sv - single-master request/response demux over the SoC peripheral map
//
// Purpose:
//   Decodes each master request address against the fixed 11-region
//   peripheral map and forwards it to one slave port. Unmapped addresses go to
//   an internal error responder (target index NumSlv). All in-flight requests
//   share one target, so responses return in request order without a
//   reorder buffer.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_*_i / req_ready_o   master request channel (valid/ready)
//   slv_req_valid_o         one-hot request valid, one bit per slave
//   slv_req_ready_i         per-slave request ready
//   slv_addr_o/we/wdata/be  shared request payload, combinational copy of req_*
//   slv_rsp_valid_i         per-slave response valid
//   slv_rsp_ready_o         per-slave response ready (only the current target)
//   slv_rsp_rdata_i         per-slave read data, slave i at [i*DataWidth +: DataWidth]
//   slv_rsp_err_i           per-slave error flag
//   rsp_*_o / rsp_ready_i   master response channel (valid/ready)
//   outstanding_o           number of in-flight requests
//   spurious_o              pulses while any slave responds out of turn

module soc_periph_demux #(
  parameter int unsigned NumSlv         = 11,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DataWidth      = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,

  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [63:0]                   req_addr_i,
  input  logic                          req_we_i,
  input  logic [DataWidth-1:0]          req_wdata_i,
  input  logic [DataWidth/8-1:0]        req_be_i,

  output logic [NumSlv-1:0]             slv_req_valid_o,
  input  logic [NumSlv-1:0]             slv_req_ready_i,
  output logic [63:0]                   slv_addr_o,
  output logic                          slv_we_o,
  output logic [DataWidth-1:0]          slv_wdata_o,
  output logic [DataWidth/8-1:0]        slv_be_o,

  input  logic [NumSlv-1:0]             slv_rsp_valid_i,
  output logic [NumSlv-1:0]             slv_rsp_ready_o,
  input  logic [NumSlv*DataWidth-1:0]   slv_rsp_rdata_i,
  input  logic [NumSlv-1:0]             slv_rsp_err_i,

  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          rsp_err_o,

  output logic [3:0]                    outstanding_o,
  output logic                          spurious_o
);

  // Target index NumSlv is the internal error responder.
  localparam logic [3:0] ErrIdx = 4'(NumSlv);
  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

  // Region table in slave-port order; the end bound is exclusive.
  localparam logic [63:0] RegionBase [0:10] = '{
    64'h0000_0000_8000_0000,  // DRAM
    64'h0000_0000_4001_0000,  // Trigger
    64'h0000_0000_4000_0000,  // GPIO
    64'h0000_0000_3000_0000,  // Ethernet
    64'h0000_0000_2000_0000,  // SPI
    64'h0000_0000_1800_0000,  // Timer
    64'h0000_0000_1000_0000,  // UART
    64'h0000_0000_0C00_0000,  // PLIC
    64'h0000_0000_0200_0000,  // CLINT
    64'h0000_0000_0001_0000,  // ROM
    64'h0000_0000_0000_0000   // Debug
  };

  localparam logic [63:0] RegionLen [0:10] = '{
    64'h0000_0000_4000_0000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0080_0000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_03FF_FFFF,
    64'h0000_0000_000C_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0000_1000
  };

  logic [3:0]           cnt;
  logic [3:0]           cur_tgt;
  logic [3:0]           dec_tgt;
  logic                 accept_ok;
  logic                 req_accept;
  logic                 rsp_hs;
  logic                 sel_rsp_valid;
  logic [DataWidth-1:0] sel_rsp_rdata;
  logic                 sel_rsp_err;

  // Shared request payload is a plain pass-through.
  assign slv_addr_o  = req_addr_i;
  assign slv_we_o    = req_we_i;
  assign slv_wdata_o = req_wdata_i;
  assign slv_be_o    = req_be_i;

  // Address decode: regions are disjoint, so at most one hit.
  always_comb begin
    dec_tgt = ErrIdx;
    for (int i = 0; i < 11; i++) begin
      if (req_addr_i >= RegionBase[i] &&
          req_addr_i < (RegionBase[i] + RegionLen[i])) begin
        dec_tgt = 4'(i);
      end
    end
  end

  // Switching target only when nothing is in flight keeps responses ordered.
  // Both terms use the registered count, so a response completing the last
  // transaction this cycle does not yet allow a switch.
  assign accept_ok = rst_ni && (cnt < MaxCnt) &&
                     ((cnt == 4'd0) || (dec_tgt == cur_tgt));

  always_comb begin
    req_ready_o     = 1'b0;
    slv_req_valid_o = '0;
    if (accept_ok) begin
      if (dec_tgt == ErrIdx) begin
        req_ready_o = 1'b1;
      end else begin
        for (int i = 0; i < NumSlv; i++) begin
          if (dec_tgt == 4'(i)) begin
            req_ready_o        = slv_req_ready_i[i];
            slv_req_valid_o[i] = req_valid_i;
          end
        end
      end
    end
  end

  assign req_accept = req_valid_i && req_ready_o;

  // Select the current target's response lane.
  always_comb begin
    sel_rsp_valid = 1'b0;
    sel_rsp_rdata = '0;
    sel_rsp_err   = 1'b0;
    for (int i = 0; i < NumSlv; i++) begin
      if (cur_tgt == 4'(i)) begin
        sel_rsp_valid = slv_rsp_valid_i[i];
        sel_rsp_rdata = slv_rsp_rdata_i[i*DataWidth +: DataWidth];
        sel_rsp_err   = slv_rsp_err_i[i];
      end
    end
  end

  always_comb begin
    rsp_valid_o     = 1'b0;
    rsp_rdata_o     = '0;
    rsp_err_o       = 1'b0;
    slv_rsp_ready_o = '0;
    if (cnt != 4'd0) begin
      if (cur_tgt == ErrIdx) begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = 1'b1;
      end else begin
        rsp_valid_o = sel_rsp_valid;
        rsp_rdata_o = sel_rsp_rdata;
        rsp_err_o   = sel_rsp_err;
        for (int i = 0; i < NumSlv; i++) begin
          if (cur_tgt == 4'(i)) begin
            slv_rsp_ready_o[i] = rsp_ready_i;
          end
        end
      end
    end
  end

  assign rsp_hs = rsp_valid_o && rsp_ready_i;

  // A slave is out of turn when it is not the current target or nothing is
  // in flight; its response is left unconsumed.
  always_comb begin
    spurious_o = 1'b0;
    if (rst_ni) begin
      for (int i = 0; i < NumSlv; i++) begin
        if (slv_rsp_valid_i[i] && ((cur_tgt != 4'(i)) || (cnt == 4'd0))) begin
          spurious_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= 4'd0;
      cur_tgt <= 4'd0;
    end else begin
      if (req_accept) begin
        cur_tgt <= dec_tgt;
      end
      if (req_accept && !rsp_hs) begin
        cnt <= cnt + 4'd1;
      end else if (!req_accept && rsp_hs) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign outstanding_o = cnt;

endmodule

// File: tb/tb_soc_periph_demux.sv
// tb/tb_soc_periph_demux.sv - self-checking bench for soc_periph_demux
module tb_soc_periph_demux;

  localparam int NS = 11;
  localparam int DW = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [63:0]       req_addr_i;
  logic              req_we_i;
  logic [DW-1:0]     req_wdata_i;
  logic [DW/8-1:0]   req_be_i;
  logic [NS-1:0]     slv_req_valid_o;
  logic [NS-1:0]     slv_req_ready_i;
  logic [63:0]       slv_addr_o;
  logic              slv_we_o;
  logic [DW-1:0]     slv_wdata_o;
  logic [DW/8-1:0]   slv_be_o;
  logic [NS-1:0]     slv_rsp_valid_i;
  logic [NS-1:0]     slv_rsp_ready_o;
  logic [NS*DW-1:0]  slv_rsp_rdata_i;
  logic [NS-1:0]     slv_rsp_err_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DW-1:0]     rsp_rdata_o;
  logic              rsp_err_o;
  logic [3:0]        outstanding_o;
  logic              spurious_o;

  int tests = 0;
  int fails = 0;

  soc_periph_demux #(.NumSlv(NS), .MaxOutstanding(4), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .slv_req_valid_o(slv_req_valid_o), .slv_req_ready_i(slv_req_ready_i),
    .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o), .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o),
    .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_ready_o(slv_rsp_ready_o),
    .slv_rsp_rdata_i(slv_rsp_rdata_i), .slv_rsp_err_i(slv_rsp_err_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .outstanding_o(outstanding_o), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] rbase [11] = '{64'h8000_0000, 64'h4001_0000, 64'h4000_0000, 64'h3000_0000,
                              64'h2000_0000, 64'h1800_0000, 64'h1000_0000, 64'h0C00_0000,
                              64'h0200_0000, 64'h0001_0000, 64'h0000_0000};
  logic [63:0] rlen  [11] = '{64'h4000_0000, 64'h1000, 64'h1000, 64'h1_0000,
                              64'h80_0000, 64'h1000, 64'h1000, 64'h3FF_FFFF,
                              64'hC_0000, 64'h1_0000, 64'h1000};

  function automatic int ref_decode(logic [63:0] a);
    for (int i = 0; i < 11; i++)
      if (a >= rbase[i] && a - rbase[i] < rlen[i]) return i;
    return 11;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_rsp(int s, logic [63:0] d, logic e);
    slv_rsp_valid_i = '0;
    slv_rsp_valid_i[s] = 1'b1;
    slv_rsp_rdata_i[s*DW +: DW] = d;
    slv_rsp_err_i[s] = e;
  endtask

  // Reference state: queue of targets of in-flight requests, plus the target
  // of the most recently accepted request.
  int q[$];
  int last_tgt;

  initial begin
    logic [63:0] baddr [4];
    int          bexp  [4];
    rst_ni = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 64'h1000_0004; req_we_i = 1'b0;
    req_wdata_i = '0; req_be_i = '1;
    slv_req_ready_i = '1; slv_rsp_valid_i = 11'h020; slv_rsp_rdata_i = '0;
    slv_rsp_err_i = '0; rsp_ready_i = 1'b0;
    tick(); tick();
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_slv_req_valid", slv_req_valid_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_slv_rsp_ready", slv_rsp_ready_o, 0);
    chk("rst_spurious", spurious_o, 0);
    req_valid_i = 1'b0; slv_rsp_valid_i = '0;
    rst_ni = 1'b1;
    #1;

    // UART read
    req_valid_i = 1'b1; req_addr_i = 64'h1000_0004; req_wdata_i = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("uart_slv_req_valid", slv_req_valid_o, 64'h40);
    chk("uart_req_ready", req_ready_o, 1);
    chk("uart_addr_copy", slv_addr_o, 64'h1000_0004);
    chk("uart_wdata_copy", slv_wdata_o, 64'h1234_5678_9ABC_DEF0);
    tick();
    req_valid_i = 1'b0;
    chk("uart_out1", outstanding_o, 1);
    set_rsp(6, 64'hAB, 1'b0); rsp_ready_i = 1'b1;
    #1;
    chk("uart_rsp_valid", rsp_valid_o, 1);
    chk("uart_rsp_rdata", rsp_rdata_o, 64'hAB);
    chk("uart_rsp_err", rsp_err_o, 0);
    chk("uart_slv_rsp_ready", slv_rsp_ready_o, 64'h40);
    chk("uart_spurious", spurious_o, 0);
    tick();
    slv_rsp_valid_i = '0;
    chk("uart_out0", outstanding_o, 0);

    // Unmapped write
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 64'h5000_0000;
    #1;
    chk("err_req_ready", req_ready_o, 1);
    chk("err_slv_req_valid", slv_req_valid_o, 0);
    chk("err_rsp_valid_accept_cycle", rsp_valid_o, 0);
    tick();
    req_valid_i = 1'b0; req_we_i = 1'b0;
    chk("err_rsp_valid", rsp_valid_o, 1);
    chk("err_rsp_err", rsp_err_o, 1);
    chk("err_rsp_rdata", rsp_rdata_o, 0);
    tick();
    chk("err_out0", outstanding_o, 0);

    // Four DRAM reads fill the tracker
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid_i = 1'b1; req_addr_i = 64'h8000_0000 + 64'(k * 8);
      #1;
      chk("dram_fill_ready", req_ready_o, 1);
      tick();
    end
    chk("dram_out4", outstanding_o, 4);
    chk("dram_full_ready", req_ready_o, 0);
    chk("dram_full_valid", slv_req_valid_o, 0);
    set_rsp(0, 64'h11, 1'b0); rsp_ready_i = 1'b1;
    #1;
    chk("dram_full_rsp_ready_still0", req_ready_o, 0);
    tick();
    slv_rsp_valid_i = '0;
    chk("dram_out3", outstanding_o, 3);
    chk("dram_after_rsp_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    chk("dram_refill_out4", outstanding_o, 4);
    set_rsp(0, 64'h22, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    slv_rsp_valid_i = '0;
    chk("dram_drain_out0", outstanding_o, 0);

    // GPIO outstanding blocks a ROM request
    req_valid_i = 1'b1; req_addr_i = 64'h4000_0010;
    tick();
    req_addr_i = 64'h0001_0000;
    #1;
    chk("rom_stall_ready", req_ready_o, 0);
    chk("rom_stall_valid", slv_req_valid_o, 0);
    set_rsp(2, 64'h33, 1'b0); rsp_ready_i = 1'b1;
    #1;
    chk("rom_stall_same_cycle_rsp", req_ready_o, 0);
    chk("gpio_rsp_rdata", rsp_rdata_o, 64'h33);
    tick();
    slv_rsp_valid_i = '0;
    chk("rom_go_out0", outstanding_o, 0);
    chk("rom_go_ready", req_ready_o, 1);
    chk("rom_go_valid", slv_req_valid_o, 64'h200);
    tick();
    req_valid_i = 1'b0;
    chk("rom_out1", outstanding_o, 1);
    set_rsp(9, 64'h44, 1'b1);
    #1;
    chk("rom_rsp_err", rsp_err_o, 1);
    tick();
    slv_rsp_valid_i = '0;
    chk("rom_out0", outstanding_o, 0);

    // CLINT accept and response in the same cycle
    req_valid_i = 1'b1; req_addr_i = 64'h0200_0100; rsp_ready_i = 1'b1;
    tick(); tick();
    chk("clint_out2", outstanding_o, 2);
    set_rsp(8, 64'h55, 1'b0);
    #1;
    chk("clint_both_ready", req_ready_o, 1);
    chk("clint_both_rsp_valid", rsp_valid_o, 1);
    tick();
    req_valid_i = 1'b0;
    chk("clint_stays2", outstanding_o, 2);
    tick(); tick();
    slv_rsp_valid_i = '0;
    chk("clint_out0", outstanding_o, 0);

    // Boundary decode with all slaves stalled: ERR is the only ready target
    slv_req_ready_i = '0;
    baddr = '{64'h8000_0000, 64'hBFFF_FFFF, 64'hC000_0000, 64'h4000_FFFF};
    bexp  = '{0, 0, 11, 11};
    for (int k = 0; k < 4; k++) begin
      req_valid_i = 1'b1; req_addr_i = baddr[k];
      #1;
      chk($sformatf("bound_valid_%h", baddr[k]), slv_req_valid_o,
          (bexp[k] == 11) ? 64'h0 : (64'h1 << bexp[k]));
      chk($sformatf("bound_ready_%h", baddr[k]), req_ready_o, (bexp[k] == 11) ? 1 : 0);
    end
    req_valid_i = 1'b0; slv_req_ready_i = '1;
    #1;

    // Timer responds with nothing in flight
    set_rsp(5, 64'h66, 1'b0); rsp_ready_i = 1'b1;
    #1;
    chk("timer_spurious", spurious_o, 1);
    chk("timer_slv_rsp_ready", slv_rsp_ready_o, 0);
    chk("timer_rsp_valid", rsp_valid_o, 0);
    tick();
    slv_rsp_valid_i = '0;
    #1;
    chk("timer_spurious_gone", spurious_o, 0);
    chk("timer_out0", outstanding_o, 0);

    // Reset mid-transaction drops tracking
    req_valid_i = 1'b1; req_addr_i = 64'h1000_0000; rsp_ready_i = 1'b0;
    tick();
    chk("midrst_out1", outstanding_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_out0", outstanding_o, 0);
    chk("midrst_ready0", req_ready_o, 0);
    req_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;

    // Randomized traffic against a queue-based reference
    last_tgt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int          tgt, pick;
      logic        exp_ready, exp_rv, exp_err, exp_spur, allowed, hs;
      logic [63:0] exp_rdata, exp_sv, exp_sr;
      pick = $urandom_range(0, 9);
      if (pick < 5)      tgt = last_tgt;
      else if (pick < 9) tgt = $urandom_range(0, 11);
      else               tgt = 12;
      if (tgt < 11)       req_addr_i = rbase[tgt] + 64'($urandom_range(0, 32'(rlen[tgt] - 64'd1)));
      else if (tgt == 11) req_addr_i = 64'h5000_0000 + 64'($urandom_range(0, 255));
      else                req_addr_i = {32'h0000_0001, 32'($urandom())} & 64'hFFFF_FFFF_FFFF_FFF8;
      tgt = ref_decode(req_addr_i);
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_we_i = $urandom_range(0, 1) == 1;
      req_wdata_i = {$urandom(), $urandom()};
      slv_req_ready_i = 11'($urandom()) | 11'($urandom());
      slv_rsp_valid_i = 11'($urandom()) & 11'($urandom());
      if (q.size() > 0 && last_tgt < 11 && $urandom_range(0, 1) == 1) slv_rsp_valid_i[last_tgt] = 1'b1;
      for (int s = 0; s < NS; s++) slv_rsp_rdata_i[s*DW +: DW] = {$urandom(), $urandom()};
      slv_rsp_err_i = 11'($urandom());
      rsp_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      allowed   = (q.size() < 4) && (q.size() == 0 || tgt == last_tgt);
      exp_ready = allowed && (tgt == 11 || slv_req_ready_i[tgt]);
      exp_sv    = (allowed && tgt < 11 && req_valid_i) ? (64'h1 << tgt) : 64'h0;
      exp_rv = 1'b0; exp_rdata = '0; exp_err = 1'b0; exp_sr = '0;
      if (q.size() > 0) begin
        if (last_tgt == 11) begin
          exp_rv = 1'b1; exp_err = 1'b1;
        end else begin
          exp_rv    = slv_rsp_valid_i[last_tgt];
          exp_rdata = slv_rsp_rdata_i[last_tgt*DW +: DW];
          exp_err   = slv_rsp_err_i[last_tgt];
          exp_sr    = rsp_ready_i ? (64'h1 << last_tgt) : 64'h0;
        end
      end
      exp_spur = 1'b0;
      for (int s = 0; s < NS; s++)
        if (slv_rsp_valid_i[s] && (q.size() == 0 || s != last_tgt)) exp_spur = 1'b1;
      chk("rnd_req_ready", req_ready_o, exp_ready);
      chk("rnd_slv_req_valid", slv_req_valid_o, exp_sv);
      chk("rnd_rsp_valid", rsp_valid_o, exp_rv);
      chk("rnd_rsp_rdata", rsp_rdata_o, exp_rdata);
      chk("rnd_rsp_err", rsp_err_o, exp_err);
      chk("rnd_slv_rsp_ready", slv_rsp_ready_o, exp_sr);
      chk("rnd_spurious", spurious_o, exp_spur);
      hs = exp_rv && rsp_ready_i;
      if (hs) void'(q.pop_front());
      if (req_valid_i && exp_ready) begin
        q.push_back(tgt);
        last_tgt = tgt;
      end
      tick();
      chk("rnd_outstanding", outstanding_o, 64'(q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/soc_periph_demux.md
# soc_periph_demux

Single-master request/response demultiplexer that sits in front of the SoC peripheral map. It decodes each request address against the fixed 11-region address map and forwards the request to one slave port. It tracks outstanding transactions so responses return in request order. Unmapped addresses are absorbed by an internal error responder.

## Interface
- NumSlv, 11: slave ports; index = map order below.
- MaxOutstanding, 4: max in-flight requests; 1..15.
- DataWidth, 64: data width; strobe width is DataWidth/8.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i / req_ready_o  in/out  1  master request handshake.
- req_addr_i  in  64  byte address.
- req_we_i  in  1  write enable.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  DataWidth/8  byte strobes.
- slv_req_valid_o  out  NumSlv  one-hot request valid.
- slv_req_ready_i  in  NumSlv  per-slave request ready.
- slv_addr_o / slv_we_o / slv_wdata_o / slv_be_o  out  64/1/DataWidth/DataWidth/8  shared request payload, a combinational copy of the req_* inputs.
- slv_rsp_valid_i  in  NumSlv  per-slave response valid.
- slv_rsp_ready_o  out  NumSlv  per-slave response ready.
- slv_rsp_rdata_i  in  NumSlv×DataWidth  per-slave read data.
- slv_rsp_err_i  in  NumSlv  per-slave error.
- rsp_valid_o / rsp_ready_i  out/in  1  master response handshake.
- rsp_rdata_o  out  DataWidth  response data.
- rsp_err_o  out  1  response error.
- outstanding_o  out  4  in-flight count.
- spurious_o  out  1  one-cycle pulse on an unexpected slave response.

## Operation
- Address map, index:base/length:
  - 0 DRAM 8000_0000/4000_0000
  - 1 Trigger 4001_0000/1000
  - 2 GPIO 4000_0000/1000
  - 3 Ethernet 3000_0000/10000
  - 4 SPI 2000_0000/800000
  - 5 Timer 1800_0000/1000
  - 6 UART 1000_0000/1000
  - 7 PLIC 0C00_0000/3FF_FFFF
  - 8 CLINT 0200_0000/C0000
  - 9 ROM 0001_0000/10000
  - 10 Debug 0000_0000/1000
- Hit rule: base ≤ addr < base+length, using 64-bit unsigned compares. Regions are disjoint. No hit selects target ERR (index 11).
- Registered state: cnt (0..MaxOutstanding) and cur_tgt (0..11).
- Accept is allowed when cnt < MaxOutstanding and (cnt == 0 or decoded target == cur_tgt). Both terms use the registered cnt. A same-cycle response completing the last transaction does not enable a target switch.
- When allowed:
  - Real target t: slv_req_valid_o[t] = req_valid_i and req_ready_o = slv_req_ready_i[t].
  - ERR target: req_ready_o = 1 and no slave valid is raised.
- When not allowed: req_ready_o = 0 and all slv_req_valid_o = 0.
- On accept: cur_tgt is set to the target and cnt increments.
- Response path, when cnt > 0:
  - Real cur_tgt: rsp_valid_o/rdata/err mirror that slave's response and slv_rsp_ready_o[cur_tgt] = rsp_ready_i.
  - ERR cur_tgt: rsp_valid_o = 1, rsp_rdata_o = 0, rsp_err_o = 1.
- On response handshake: cnt decrements.
- When cnt == 0: rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, and all slv_rsp_ready_o = 0.
- Simultaneous accept and response: cnt unchanged.
- slv_rsp_ready_o is 0 for every slave other than cur_tgt. spurious_o pulses in any cycle where slv_rsp_valid_i[i] is set and (i ≠ cur_tgt or cnt == 0). That response is not consumed.

## Timing
- Request path is combinational: zero added latency.
- Response path is combinational from the selected slave: zero added latency.
- ERR response is earliest the cycle after accept, because cnt is registered.
- A slave response presented in its own accept cycle while cnt == 0 is held by the slave until the next cycle. This is legal under valid/ready.
- Reset (async assert, sync deassert by system):
  - cnt = 0, cur_tgt = 0, outstanding_o = 0, spurious_o = 0.
  - rsp_valid_o = 0, slv_rsp_ready_o = 0.
  - req_ready_o and slv_req_valid_o are forced 0 while rst_ni = 0.
- Reset mid-transaction drops all tracking. Slaves are reset alongside.

## Test plan
- Read at 0x1000_0004 (UART) with slave ready → slv_req_valid_o = 1<<6 in the same cycle. Slave replies rdata = 0xAB → rsp_rdata_o = 0xAB, rsp_err_o = 0, outstanding_o 1→0.
- Write to 0x5000_0000 (unmapped) → req_ready_o = 1 with no slv_req_valid_o. The next cycle gives rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
- Four back-to-back DRAM reads with no responses → outstanding_o = 4. A fifth request sees req_ready_o = 0 until one response completes.
- GPIO request outstanding, then a ROM request → ROM stalled (req_ready_o = 0) until the GPIO response handshakes. ROM is accepted the following cycle.
- cnt = 2 on CLINT, with a new CLINT accept and a CLINT response in the same cycle → outstanding_o stays 2.
- Boundary addresses: 0x8000_0000 selects DRAM, 0xBFFF_FFFF selects DRAM, 0xC000_0000 selects ERR, 0x4000_FFFF selects ERR. Also TIMER slave response with cnt = 0 → spurious_o pulses and slv_rsp_ready_o = 0.
